mac_cell_banked: RTL
====================

# mac_cell_banked

Parametrised, signed multiply-accumulate cell for the systolic matrix unit and successor to `mac_unit`. It holds `WEIGHT_BANKS` shadow weight registers plus one active weight, so the next tile's weights can be preloaded into any bank while the current tile streams. A 3-stage pipeline computes data × weight + last_sum, stalled by `enable`. Data is forwarded to the neighbouring cell, and a valid bit travels with each operand.

## Interface
- `DATA_WIDTH`, 9: width of data/weight operands; two's complement (`extended_byte_type` width).
- `LAST_SUM_WIDTH`, 18: width of incoming partial sum from the upstream cell; signed.
- `PARTIAL_SUM_WIDTH`, 19: output sum width; signed; must be ≥ `LAST_SUM_WIDTH`.
- `WEIGHT_BANKS`, 4: number of preload banks; ≥ 1; bank index width `BW = max(1, $clog2(WEIGHT_BANKS))`.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: advances all pipeline stages; low means every pipeline register holds.
- `weight_in` in `DATA_WIDTH`: weight to preload.
- `preload_weight` in 1: writes `weight_in` into bank `preload_bank`.
- `preload_bank` in `BW`: preload target bank.
- `load_weight` in 1: copies bank `load_bank` into the active weight.
- `load_bank` in `BW`: bank to activate.
- `data_in` in `DATA_WIDTH`: activation operand.
- `data_valid` in 1: qualifies `data_in`.
- `last_sum` in `LAST_SUM_WIDTH`: upstream partial sum, sign-extended.
- `data_out` out `DATA_WIDTH`: stage-1 data register, forwarded to the neighbour.
- `partial_sum` out `PARTIAL_SUM_WIDTH`: stage-3 sum register.
- `sum_valid` out 1: `partial_sum` holds a result from a valid operand.

## Operation
- **Reset.**
  - Clears all banks, the active weight, all pipeline registers and the valid pipe.
  - `data_out`, `partial_sum` and `sum_valid` are 0 on the edge following `rst` high.
  - Reset mid-stream discards in-flight results.
- **Preload.**
  - `preload_weight` writes the bank independently of `enable`.
  - Out-of-range bank indices, which are possible when `WEIGHT_BANKS` is not a power of two, are ignored.
- **Load.**
  - `load_weight` updates the active weight independently of `enable`.
  - If preload and load target the same bank in the same cycle, the active weight takes the *old* bank value.
- **Pipeline**, advancing only when `enable` = 1:
  - S1: `data_reg` ← `data_in`; `v1` ← `data_valid`.
  - S2: `prod_reg` ← signed(`data_reg`) × signed(active weight), 2·`DATA_WIDTH` bits; `v2` ← `v1`.
  - S3: sum ← sext(`prod_reg`) + sext(`last_sum`), computed at `max(2·DATA_WIDTH, LAST_SUM_WIDTH)+1` bits, then reduced to `PARTIAL_SUM_WIDTH` (see Configuration); `sum_valid` ← `v2`.
- **Weight binding.** The active weight used by S2 at edge k+1 multiplies data captured at edge k. A `load_weight` at edge j therefore applies to data captured at edge ≥ j.
- Invalid operands still flow through the pipeline. Downstream logic uses only `sum_valid`.

## Timing
- With no stalls, `data_in` sampled at edge k appears on `data_out` after edge k.
- Its product is registered at edge k+1.
- `partial_sum`/`sum_valid` update at edge k+2.
- `last_sum` is sampled at edge k+2, i.e. it must be presented two enabled cycles after the matching `data_in` (systolic skew).
- Each cycle with `enable` = 0 adds one cycle of latency. Outputs hold stable during a stall.
- Throughput is one result per enabled cycle. Back-to-back weight loads are allowed every cycle.

## Configuration
- `MAC_SATURATE_EN` defined: when the S3 wide sum exceeds the signed range of `PARTIAL_SUM_WIDTH`, `partial_sum` clamps to `2^(PSW-1)-1` or `-2^(PSW-1)`.
- Undefined: the sum is truncated to the low `PARTIAL_SUM_WIDTH` bits (two's-complement wrap).

## Structure
- `tpu_pkg` gets:
  - reuse of `extended_byte_type`;
  - `MAC_DEFAULT_PSUM_WIDTH` and `MAC_DEFAULT_WEIGHT_BANKS` constants;
  - a `sat_signed` function (wide value, target width), used only under `MAC_SATURATE_EN`.
- Sub-module `mac_weight_bank` holds the bank file, the active-weight register and the same-cycle preload/load rule.
- `mac_cell_banked` holds the 3-stage pipeline, the valid pipe and the saturation logic.

## Test plan
- **Reset:** drive `rst` for 1 cycle mid-stream → `partial_sum`=0, `sum_valid`=0, `data_out`=0 next edge; a later load of any bank gives active weight 0.
- **Basic:** preload bank 2=5, load bank 2, `data_in`=7 valid at edge k, `last_sum`=100 at edge k+2 → `partial_sum`=135, `sum_valid`=1 after edge k+2.
- **Signed:** weight -3, data 255, `last_sum` -1 → `partial_sum` = -766.
- **Double buffer:**
  - preload bank0=2, bank1=3, load bank0;
  - stream data 10 at edge k and load bank1 at edge k+1 with data 10 → sums 20 then 30;
  - same-cycle preload bank1=9 with load bank1 → active weight stays 3.
- **Stall:** hold `enable` low 3 cycles after capturing data 4 with weight 6, `last_sum` 0 → `partial_sum` stays unchanged during the stall and is 24 after the 3rd enabled edge.
- **Overflow:** with `PSW`=17, `LSW`=16, weight 255, data 255, `last_sum` 1000 → 65535 with `MAC_SATURATE_EN`, -65047 without.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and constants for the systolic matrix unit.
// sat_signed is referenced only when MAC_SATURATE_EN is defined.
package tpu_pkg;

    typedef logic signed [8:0] extended_byte_type;

    localparam int MAC_DEFAULT_PSUM_WIDTH   = 19;
    localparam int MAC_DEFAULT_WEIGHT_BANKS = 4;
    localparam int SAT_WIDE_W               = 64;

    // Clamp a sign-extended wide value into the signed range of 'width' bits.
    function automatic logic signed [SAT_WIDE_W-1:0] sat_signed(
        input logic signed [SAT_WIDE_W-1:0] value,
        input int                           width
    );
        logic signed [SAT_WIDE_W-1:0] hi;
        logic signed [SAT_WIDE_W-1:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/mac_weight_bank.sv
// Shadow weight bank file plus the active weight register of a MAC cell.
// Preload and load ignore the pipeline enable; a same-cycle load sees the old bank value.
module mac_weight_bank import tpu_pkg::*; #(
    parameter int  DATA_WIDTH   = $bits(extended_byte_type),
    parameter int  WEIGHT_BANKS = MAC_DEFAULT_WEIGHT_BANKS,
    localparam int BW           = (WEIGHT_BANKS > 1) ? $clog2(WEIGHT_BANKS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] weight_in,
    input  logic                         preload_weight,
    input  logic        [BW-1:0]         preload_bank,
    input  logic                         load_weight,
    input  logic        [BW-1:0]         load_bank,
    output logic signed [DATA_WIDTH-1:0] active_weight_o
);

    logic signed [DATA_WIDTH-1:0] bank_q [WEIGHT_BANKS];
    logic signed [DATA_WIDTH-1:0] active_q;
    logic signed [DATA_WIDTH-1:0] active_d;
    logic                         preload_ok;
    logic                         load_ok;

    // Indices past WEIGHT_BANKS-1 exist when the bank count is not a power of two.
    assign preload_ok = preload_weight && (int'(preload_bank) < WEIGHT_BANKS);
    assign load_ok    = load_weight && (int'(load_bank) < WEIGHT_BANKS);

    always_comb begin
        active_d = active_q;
        if (load_ok) begin
            active_d = bank_q[load_bank];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WEIGHT_BANKS; i++) begin
                bank_q[i] <= '0;
            end
            active_q <= '0;
        end else begin
            if (preload_ok) begin
                bank_q[preload_bank] <= weight_in;
            end
            active_q <= active_d;
        end
    end

    assign active_weight_o = active_q;

endmodule

// File: rtl/mac_cell_banked.sv
// Banked-weight signed multiply-accumulate cell, 3-stage pipeline stalled by enable.
// Define MAC_SATURATE_EN to clamp partial_sum instead of wrapping it.
module mac_cell_banked import tpu_pkg::*; #(
    parameter int  DATA_WIDTH        = $bits(extended_byte_type),
    parameter int  LAST_SUM_WIDTH    = 18,
    parameter int  PARTIAL_SUM_WIDTH = MAC_DEFAULT_PSUM_WIDTH,
    parameter int  WEIGHT_BANKS      = MAC_DEFAULT_WEIGHT_BANKS,
    localparam int BW                = (WEIGHT_BANKS > 1) ? $clog2(WEIGHT_BANKS) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,
    input  logic signed [DATA_WIDTH-1:0]        weight_in,
    input  logic                                preload_weight,
    input  logic        [BW-1:0]                preload_bank,
    input  logic                                load_weight,
    input  logic        [BW-1:0]                load_bank,
    input  logic signed [DATA_WIDTH-1:0]        data_in,
    input  logic                                data_valid,
    input  logic signed [LAST_SUM_WIDTH-1:0]    last_sum,
    output logic signed [DATA_WIDTH-1:0]        data_out,
    output logic signed [PARTIAL_SUM_WIDTH-1:0] partial_sum,
    output logic                                sum_valid
);

    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int WIDE_W = ((PROD_W > LAST_SUM_WIDTH) ? PROD_W : LAST_SUM_WIDTH) + 1;

    logic signed [DATA_WIDTH-1:0]        active_w;
    logic signed [DATA_WIDTH-1:0]        data_p1_q;
    logic                                vld_p1_q;
    logic signed [PROD_W-1:0]            prod_p2_d;
    logic signed [PROD_W-1:0]            prod_p2_q;
    logic                                vld_p2_q;
    logic signed [WIDE_W-1:0]            wide_sum;
    logic signed [PARTIAL_SUM_WIDTH-1:0] psum_p3_d;
    logic signed [PARTIAL_SUM_WIDTH-1:0] psum_p3_q;
    logic                                vld_p3_q;

    mac_weight_bank #(
        .DATA_WIDTH   (DATA_WIDTH),
        .WEIGHT_BANKS (WEIGHT_BANKS)
    ) u_weight_bank (
        .clk             (clk),
        .rst             (rst),
        .weight_in       (weight_in),
        .preload_weight  (preload_weight),
        .preload_bank    (preload_bank),
        .load_weight     (load_weight),
        .load_bank       (load_bank),
        .active_weight_o (active_w)
    );

    // S1 -> S2: operands are sign-extended first so the product is exact.
    assign prod_p2_d = PROD_W'(data_p1_q) * PROD_W'(active_w);

    // S2 -> S3: one guard bit above the wider addend keeps the sum exact before reduction.
    assign wide_sum = WIDE_W'(prod_p2_q) + WIDE_W'(last_sum);

`ifdef MAC_SATURATE_EN
    assign psum_p3_d = PARTIAL_SUM_WIDTH'(sat_signed(SAT_WIDE_W'(wide_sum), PARTIAL_SUM_WIDTH));
`else
    assign psum_p3_d = PARTIAL_SUM_WIDTH'(wide_sum);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            data_p1_q <= '0;
            vld_p1_q  <= 1'b0;
            prod_p2_q <= '0;
            vld_p2_q  <= 1'b0;
            psum_p3_q <= '0;
            vld_p3_q  <= 1'b0;
        end else if (enable) begin
            data_p1_q <= data_in;
            vld_p1_q  <= data_valid;
            prod_p2_q <= prod_p2_d;
            vld_p2_q  <= vld_p1_q;
            psum_p3_q <= psum_p3_d;
            vld_p3_q  <= vld_p2_q;
        end
    end

    assign data_out    = data_p1_q;
    assign partial_sum = psum_p3_q;
    assign sum_valid   = vld_p3_q;

endmodule
